nibble_serial_subtractor: RTL and testbench
===========================================

// Module: nibble_serial_subtractor
// PURPOSE
//  Multi-cycle two's-complement subtractor: D = A - B - Bin, computed one
//  4-bit nibble per clock through a single internal 4-bit carry-lookahead
//  slice (A + ~B + carry). It is the subtract-direction companion of the
//  4-bit CLA adder and is used where area matters more than latency.
//  A start/busy/done handshake connects it to a controller or testbench.
// PARAMETERS
//  WIDTH    16   operand/result width in bits; must be a multiple of 4, >= 8
//  NIB      WIDTH/4 (localparam) nibble count = RUN cycles per operation
// PORTS
//  clk      in   1      rising-edge clock, single clock domain
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only in IDLE or DONE
//  A        in   WIDTH  minuend; sampled on the accepted start edge
//  B        in   WIDTH  subtrahend; sampled on the accepted start edge
//  Bin      in   1      borrow-in; sampled on the accepted start edge
//  busy     out  1      high while in RUN
//  done     out  1      one-cycle pulse: D/Bout/V valid
//  D        out  WIDTH  difference; held from done until the next accepted start
//  Bout     out  1      borrow-out (1 = unsigned A < B + Bin)
//  V        out  1      signed overflow of A - B - Bin
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, busy=0, done=0, D=0, Bout=0, V=0,
//    nibble counter=0, internal carry=0, operand registers=0.
//  States: IDLE -> RUN on start; RUN -> DONE after NIB nibble cycles;
//    DONE -> RUN if start is high, else DONE -> IDLE. DONE lasts one cycle.
//  Accept edge: latch A, B, Bin, set carry=~Bin, set cnt=0, and clear D,
//    Bout and V to 0.
//  RUN, one edge per nibble i=cnt (LSB nibble first):
//    {c,s} = A[4i+3:4i] + ~B[4i+3:4i] + carry. Write D[4i+3:4i]=s and carry=c.
//    Increment cnt. On i=NIB-1 go to DONE.
//  Final values, registered on the last RUN edge:
//    Bout = ~c_final.
//    V = (A[MSB]^B[MSB]) & (D[MSB]^A[MSB]).
//  Latency: start accepted at edge k -> done=1 during the cycle after edge
//    k+NIB (NIB+1 edges from accept to done, i.e. 5 for WIDTH=16).
//  busy=1 exactly in RUN. done=1 exactly in DONE. Outputs are registered,
//    with no combinational path from inputs to outputs.
//  start in RUN is ignored; in-flight operands are unaffected.
//  Back-to-back: start high in DONE is accepted on that edge. The done
//    pulse is still seen and D is then cleared.
//  Partial D nibbles are visible during RUN and are not valid until done.
//  Reset mid-RUN aborts immediately: no done pulse, all outputs at reset values.
//  A, B and Bin may change freely after the accept edge.
// TESTING (WIDTH=16)
//  A=0x0005, B=0x0003, Bin=0: D=0x0002, Bout=0, V=0; done 5 edges after accept.
//  A=0x0000, B=0x0001, Bin=0: D=0xFFFF, Bout=1, V=0.
//  A=0x8000, B=0x0001, Bin=0: D=0x7FFF, Bout=0, V=1.
//    Also A=0x7FFF, B=0xFFFF: D=0x8000, Bout=1, V=1.
//  A=0x1000, B=0x0FFF, Bin=1: D=0x0000, Bout=0, V=0 (borrow ripples across
//    all nibbles).
//  Pulse start with new operands while busy: ignored; first result unchanged.
//    Then hold start through DONE: second operation is accepted back-to-back.
//  Assert rst_n=0 during the 2nd RUN cycle: all outputs are 0 at once and
//    no done pulse follows. A fresh start after release then completes normally.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Serial two's-complement subtractor: D = A - B - Bin, one 4-bit nibble per clock
// through a single A + ~B + carry slice, with a start/busy/done handshake.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16  // multiple of 4, >= 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Handshake: start is accepted on a rising edge only while in IDLE or DONE;
  // busy is high exactly in RUN, done pulses for the single DONE cycle, and
  // D/Bout/V stay stable from done until the next accepted start.
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, bout_q, v_q;

  logic [CW+1:0]    nib_sel;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       sum_d;
  logic             last_nib;

  always_comb begin
    nib_sel  = {cnt_q, 2'b00};
    a_nib    = a_q[nib_sel +: 4];
    b_nib    = b_q[nib_sel +: 4];
    sum_d    = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
    last_nib = (cnt_q == CW'(NIB - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            a_q     <= A;
            b_q     <= B;
            carry_q <= ~Bin;  // borrow-in expressed as an inverted carry-in
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          d_q[nib_sel +: 4] <= sum_d[3:0];
          carry_q           <= sum_d[4];
          cnt_q             <= cnt_q + CW'(1);
          if (last_nib) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bout_q  <= ~sum_d[4];
            // sum_d[3] is the result MSB being written on this same edge
            v_q     <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum_d[3] ^ a_q[WIDTH-1]);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16) with an
// expected-result queue filled at stimulus time and drained on each done pulse.
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic         clk, rst_n, start, Bin;
  logic [W-1:0] A, B, D;
  logic         busy, done, Bout, V;

  logic [W+1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  logic [W-1:0] last_d;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .D(D), .Bout(Bout), .V(V)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    logic [W:0]   f;
    logic [W-1:0] d;
    logic         v;
    f = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d = f[W-1:0];
    v = (a[W-1] ^ b[W-1]) & (d[W-1] ^ a[W-1]);
    return {d, f[W], v};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [W+1:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("D", 32'(D), 32'(e[W+1:2]));
        check("Bout", 32'(Bout), 32'(e[1]));
        check("V", 32'(V), 32'(e[0]));
        check("busy_at_done", 32'(busy), 32'd0);
        last_d = e[W+1:2];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a; B = b; Bin = bin; start = 1'b1;
    exp_q.push_back(model(a, b, bin));
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom_range(0, 1));
  endtask

  // Counts negedges after the accept edge until done; returns #1 after the next rising edge.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) check("busy_in_run", 32'(busy), 32'd1);
    end while (!done && n < 20);
    if (!done) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] va[5], vb[5];
  logic         vbin[5];

  initial begin
    int n;
    int dc;
    va[0] = 16'h0005; vb[0] = 16'h0003; vbin[0] = 1'b0;
    va[1] = 16'h0000; vb[1] = 16'h0001; vbin[1] = 1'b0;
    va[2] = 16'h8000; vb[2] = 16'h0001; vbin[2] = 1'b0;
    va[3] = 16'h7FFF; vb[3] = 16'hFFFF; vbin[3] = 1'b0;
    va[4] = 16'h1000; vb[4] = 16'h0FFF; vbin[4] = 1'b1;

    start = 1'b0; A = '0; B = '0; Bin = 1'b0; last_d = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_V", 32'(V), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, including latency and hold-after-done
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vbin[i]);
      wait_done(n);
      check("latency", 32'(n), 32'd5);
      @(posedge clk); #1;
      check("D_hold", 32'(D), 32'(last_d));
      check("done_low_idle", 32'(done), 32'd0);
    end

    // Start pulse during RUN must be ignored
    start_op(16'h1234, 16'h0034, 1'b0);
    @(posedge clk); #1;
    A = 16'hFFFF; B = 16'h0001; Bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = done_cnt;
    wait_done(n);
    check("ignored_start_one_done", 32'(done_cnt - dc), 32'd1);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Back-to-back: start held through DONE
    A = 16'h00F0; B = 16'h000F; Bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(16'h00F0, 16'h000F, 1'b0));
    @(posedge clk); #1;
    A = 16'h0001; B = 16'h0002; Bin = 1'b1;
    exp_q.push_back(model(16'h0001, 16'h0002, 1'b1));
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    check("b2b_first_latency", 32'(n), 32'd5);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_D_cleared", 32'(D), 32'd0);
    wait_done(n);
    check("b2b_second_latency", 32'(n), 32'd5);

    // Reset during the 2nd RUN cycle aborts
    start_op(16'h4321, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_D", 32'(D), 32'd0);
    check("abort_Bout", 32'(Bout), 32'd0);
    check("abort_V", 32'(V), 32'd0);
    dc = done_cnt;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - dc), 32'd0);
    start_op(16'h00FF, 16'h0100, 1'b1);
    wait_done(n);
    check("post_reset_latency", 32'(n), 32'd5);

    // Random operations
    for (int i = 0; i < 10; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      wait_done(n);
      check("rand_latency", 32'(n), 32'd5);
    end

    repeat (2) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
